pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives write-enables and flushes for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 17 +
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the bundle of per-stage write/flush controls with its canonical patterns.
package pipe_hazard_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'b00,
    ST_FLUSH    = 2'b01,
    ST_MEM_WAIT = 2'b10
  } ctrl_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_RUN        = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_out_t CTRL_FREEZE     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_out_t CTRL_BRANCH     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_out_t CTRL_FLUSH_HOLD = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_out_t CTRL_LOAD_USE   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_out_t CTRL_RESET      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline-side hazard inputs plus the stage controls
// returned to the pipeline registers.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic               id_uses_rt;
  logic               ex_mem_read;
  logic [REG_AW-1:0]  ex_rt;
  logic               ex_branch_taken;
  logic               mem_req;
  logic               mem_ready;

  logic               pc_write;
  logic               if_id_write;
  logic               id_ex_write;
  logic               ex_mem_write;
  logic               if_id_flush;
  logic               id_ex_flush;
  logic               mem_wb_bubble;
  logic [STATE_W-1:0] ctrl_state;
  logic               mem_timeout;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush,
           mem_wb_bubble, ctrl_state, mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush,
           mem_wb_bubble, ctrl_state, mem_timeout
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction
// reads. Register 0 is hardwired and never creates a dependency.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  output logic              hazard_o
);

  assign hazard_o = ex_mem_read_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (MEM wait > taken branch > load-use).
// Define PIPE_HAZARD_STATS_EN to add saturating stall/flush/timeout counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]   stall_cycles_o,
  output logic [CNT_W-1:0]   flush_events_o,
  output logic [CNT_W-1:0]   timeout_events_o
`endif
);

  localparam logic [CNT_W-1:0] WAIT_MAX_C   = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] FLUSH_LAST_C = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE_C;
  endfunction

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             timeout_q, timeout_d;
  ctrl_out_t        ctrl;
  ctrl_out_t        ctrl_out;
  logic             hazard;
  logic             mem_stall;
  logic             branch_go;
  logic             timeout_hit;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use (
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .id_uses_rt_i  (bus.id_uses_rt),
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_rt_i       (bus.ex_rt),
    .hazard_o      (hazard)
  );

  assign mem_stall = bus.mem_req && !bus.mem_ready;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    ctrl        = CTRL_RUN;
    branch_go   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          ctrl       = CTRL_FREEZE;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = ONE_C;
        end else if (bus.ex_branch_taken) begin
          branch_go = 1'b1;
        end else if (hazard) begin
          ctrl = CTRL_LOAD_USE;
        end
      end
      ST_FLUSH: begin
        if (mem_stall) begin
          ctrl       = CTRL_FREEZE;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = ONE_C;
        end else begin
          ctrl = CTRL_FLUSH_HOLD;
          if (flush_cnt_q == FLUSH_LAST_C) state_d = ST_RUN;
          else flush_cnt_d = sat_inc(flush_cnt_q);
        end
      end
      ST_MEM_WAIT: begin
        // Timeout releases exactly like a ready; the branch still sitting in EX is re-evaluated here.
        if (bus.mem_ready || (wait_cnt_q == WAIT_MAX_C)) begin
          state_d     = ST_RUN;
          timeout_hit = !bus.mem_ready;
          if (timeout_hit) timeout_d = 1'b1;
          branch_go   = bus.ex_branch_taken;
        end else begin
          ctrl       = CTRL_FREEZE;
          wait_cnt_d = sat_inc(wait_cnt_q);
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (branch_go) begin
      ctrl = CTRL_BRANCH;
      if (FLUSH_CYCLES > 1) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = ONE_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ctrl_out          = rst ? CTRL_RESET : ctrl;
  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.if_id_write   = ctrl_out.if_id_write;
  assign bus.id_ex_write   = ctrl_out.id_ex_write;
  assign bus.ex_mem_write  = ctrl_out.ex_mem_write;
  assign bus.if_id_flush   = ctrl_out.if_id_flush;
  assign bus.id_ex_flush   = ctrl_out.id_ex_flush;
  assign bus.mem_wb_bubble = ctrl_out.mem_wb_bubble;
  assign bus.ctrl_state    = rst ? ST_RUN : state_q;
  assign bus.mem_timeout   = rst ? 1'b0 : timeout_q;

`ifdef PIPE_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_events_q, timeout_events_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q   <= '0;
      flush_events_q   <= '0;
      timeout_events_q <= '0;
    end else begin
      if (!ctrl.pc_write) stall_cycles_q   <= sat_inc(stall_cycles_q);
      if (branch_go)      flush_events_q   <= sat_inc(flush_events_q);
      if (timeout_hit)    timeout_events_q <= sat_inc(timeout_events_q);
    end
  end

  assign stall_cycles_o   = stall_cycles_q;
  assign flush_events_o   = flush_events_q;
  assign timeout_events_o = timeout_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (FLUSH_CYCLES=3): directed vectors, literal
// expectations, and a rule-level model compared every cycle.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW       = 5;
  localparam int FLUSH_CYCLES = 3;
  localparam int MEM_WAIT_MAX = 15;
  localparam int CNT_W        = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

`ifdef PIPE_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles, flush_events, timeout_events;
`endif

  pipe_hazard_ctrl #(
    .REG_AW       (REG_AW),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_HAZARD_STATS_EN
    ,
    .stall_cycles_o   (stall_cycles),
    .flush_events_o   (flush_events),
    .timeout_events_o (timeout_events)
`endif
  );

  always #5 clk = ~clk;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_bubble}
  logic [6:0] ctl;
  assign ctl = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: waiting on memory, frozen cycles spent so far, flush cycles still owed, sticky timeout.
  bit m_wait = 1'b0;
  int m_frozen = 0;
  int m_flush_left = 0;
  bit m_to = 1'b0;

  always @(negedge clk) begin
    logic [6:0] e_ctl;
    logic [1:0] e_st;
    bit         e_to;
    bit         hz, stall_req, br_resp;
    cyc++;
    hz = bus.ex_mem_read && (bus.ex_rt != 0) &&
         ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    stall_req = bus.mem_req && !bus.mem_ready;
    br_resp = 1'b0;
    e_ctl = 7'b1111000;
    e_st  = m_wait ? 2'd2 : ((m_flush_left > 0) ? 2'd1 : 2'd0);
    e_to  = m_to;
    if (rst) begin
      e_ctl = 7'b0000111;
      e_st  = 2'd0;
      e_to  = 1'b0;
      m_wait = 1'b0; m_frozen = 0; m_flush_left = 0; m_to = 1'b0;
    end else if (m_wait) begin
      if (bus.mem_ready || m_frozen >= MEM_WAIT_MAX) begin
        if (!bus.mem_ready) m_to = 1'b1;
        m_wait = 1'b0;
        br_resp = bus.ex_branch_taken;
      end else begin
        e_ctl = 7'b0000001;
        m_frozen++;
      end
    end else if (m_flush_left > 0) begin
      if (stall_req) begin
        e_ctl = 7'b0000001;
        m_wait = 1'b1; m_frozen = 1; m_flush_left = 0;
      end else begin
        e_ctl = 7'b1111100;
        m_flush_left--;
      end
    end else begin
      if (stall_req) begin
        e_ctl = 7'b0000001;
        m_wait = 1'b1; m_frozen = 1;
      end else if (bus.ex_branch_taken) begin
        br_resp = 1'b1;
      end else if (hz) begin
        e_ctl = 7'b0011010;
      end
    end
    if (br_resp) begin
      e_ctl = 7'b1111110;
      m_flush_left = FLUSH_CYCLES - 1;
    end
    total++;
    if (ctl !== e_ctl || bus.ctrl_state !== e_st || bus.mem_timeout !== e_to) begin
      bad++;
      $display("FAIL model cycle%0d ctl actual=%b required=%b state actual=%b required=%b timeout actual=%b required=%b",
               cyc, ctl, e_ctl, bus.ctrl_state, e_st, bus.mem_timeout, e_to);
    end
  end

  task automatic clr();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rt = '0; bus.ex_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    // Reset
    @(negedge clk);
    chk("rst_ctl", int'(ctl), 'h07);
    chk("rst_state", int'(bus.ctrl_state), 0);
    chk("rst_timeout", int'(bus.mem_timeout), 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("run_ctl", int'(ctl), 'h78);

    // Load-use on rs, then on rt, then rt ignored, then r0
    nxt(); bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
    @(negedge clk);
    chk("lu_pc_write", int'(bus.pc_write), 0);
    chk("lu_if_id_write", int'(bus.if_id_write), 0);
    chk("lu_id_ex_flush", int'(bus.id_ex_flush), 1);
    chk("lu_state", int'(bus.ctrl_state), 0);
    nxt(); clr();
    @(negedge clk);
    chk("lu_once", int'(ctl), 'h78);
    nxt(); bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rt = 5'd5; bus.id_uses_rt = 1'b1;
    nxt(); bus.id_uses_rt = 1'b0;
    @(negedge clk);
    chk("lu_rt_unused", int'(ctl), 'h78);
    nxt(); bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
    @(negedge clk);
    chk("lu_r0", int'(bus.pc_write), 1);
    nxt(); clr();

    // Taken branch, 3 flush cycles
    nxt(); bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("br0_flush", int'(bus.if_id_flush), 1);
    chk("br0_state", int'(bus.ctrl_state), 0);
    nxt(); bus.ex_branch_taken = 1'b0;
    @(negedge clk);
    chk("br1_flush", int'(bus.if_id_flush), 1);
    chk("br1_state", int'(bus.ctrl_state), 1);
    nxt();
    @(negedge clk);
    chk("br2_state", int'(bus.ctrl_state), 1);
    chk("br2_pc", int'(bus.pc_write), 1);
    nxt();
    @(negedge clk);
    chk("br3_state", int'(bus.ctrl_state), 0);
    chk("br3_flush", int'(bus.if_id_flush), 0);

    // MEM wait for 4 cycles, then ready
    nxt(); bus.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mw_bubble", int'(bus.mem_wb_bubble), 1);
      chk("mw_state", int'(bus.ctrl_state), (i == 0) ? 0 : 2);
      nxt();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("mw_release", int'(ctl), 'h78);
    nxt(); clr();
    @(negedge clk);
    chk("mw_after", int'(bus.ctrl_state), 0);

    // MEM wait arriving during a branch flush
    nxt(); bus.ex_branch_taken = 1'b1;
    nxt(); bus.ex_branch_taken = 1'b0; bus.mem_req = 1'b1;
    nxt(); nxt(); bus.mem_ready = 1'b1;
    nxt(); clr();
    @(negedge clk);
    chk("fl_mw_state", int'(bus.ctrl_state), 0);

    // Timeout
    nxt(); bus.mem_req = 1'b1;
    for (int i = 0; i < MEM_WAIT_MAX; i++) begin
      @(negedge clk);
      chk("to_frozen", int'(bus.pc_write), 0);
      nxt();
    end
    @(negedge clk);
    chk("to_release", int'(ctl), 'h78);
    nxt(); clr();
    @(negedge clk);
    chk("to_sticky", int'(bus.mem_timeout), 1);
    nxt(); nxt();
    @(negedge clk);
    chk("to_sticky2", int'(bus.mem_timeout), 1);

    // Load-use + branch + MEM wait together
    nxt();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
    bus.ex_branch_taken = 1'b1; bus.mem_req = 1'b1;
    @(negedge clk);
    chk("sim_freeze", int'(ctl), 'h01);
    nxt();
    @(negedge clk);
    chk("sim_state", int'(bus.ctrl_state), 2);
    nxt(); bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("sim_release", int'(ctl), 'h7E);
    nxt(); clr();
    @(negedge clk);
    chk("sim_flush_state", int'(bus.ctrl_state), 1);
    nxt(); nxt();
    @(negedge clk);
    chk("sim_done", int'(bus.ctrl_state), 0);

    // Reset clears timeout
    nxt(); rst = 1'b1;
    @(negedge clk);
    chk("rst2_timeout", int'(bus.mem_timeout), 0);
    nxt(); rst = 1'b0;
    @(negedge clk);
    chk("rst2_after", int'(bus.mem_timeout), 0);
    nxt(); nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
